// File: rtl/compare_arbiter.sv
// -----------------------------------------------------------------------------
// compare_arbiter
//   Shares one unsigned magnitude comparator among NUM_REQ requesters.
//   A round-robin arbiter picks a winner in IDLE and latches its operands.
//   The comparison runs in CMP. The result is held in RESP until the consumer
//   takes it. Only one comparison is in flight at any time.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[NUM_REQ]      level request per requester
//   a_bus, b_bus      packed operands, requester i at [i*CMP_WIDTH +: CMP_WIDTH]
//   gnt[NUM_REQ]      one-cycle one-hot grant (operands were captured)
//   busy              FSM is not in IDLE
//   resp_valid/ready  result handshake
//   resp_id           requester that owns the result
//   greater/equal/smaller  a>b, a==b, a<b (meaningful while resp_valid)
// -----------------------------------------------------------------------------
module compare_arbiter #(
  parameter int CMP_WIDTH = 4,
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CMP_WIDTH-1:0] a_bus,
  input  logic [NUM_REQ*CMP_WIDTH-1:0] b_bus,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_WIDTH-1:0]          resp_id,
  output logic                         greater,
  output logic                         equal,
  output logic                         smaller
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t               r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]  r_last_id, r_win_id, w_win;
  logic [CMP_WIDTH-1:0] r_a, r_b, w_a, w_b;
  logic [NUM_REQ-1:0]   w_onehot;
  logic                 w_any;

  assign w_any = |req;

  // Round-robin pick: search starts just after r_last_id and wraps around.
  // The first pass takes the lowest index at or below r_last_id, which is the
  // wrap-around candidate. The second pass overrides it with the lowest index
  // above r_last_id, if there is one.
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req[i] && (i <= int'(r_last_id))) w_win = ID_WIDTH'(i);
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req[i] && (i > int'(r_last_id))) w_win = ID_WIDTH'(i);
  end

  // Select the winner's operand slices and build its one-hot grant.
  always_comb begin
    w_a      = '0;
    w_b      = '0;
    w_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_WIDTH'(i)) begin
        w_onehot[i] = 1'b1;
        w_a         = a_bus[i*CMP_WIDTH +: CMP_WIDTH];
        w_b         = b_bus[i*CMP_WIDTH +: CMP_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = CMP;
      CMP:     w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_id  <= ID_WIDTH'(NUM_REQ-1);
      r_win_id   <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      greater    <= 1'b0;
      equal      <= 1'b0;
      smaller    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          gnt <= w_any ? w_onehot : '0;
          if (w_any) r_win_id <= w_win;
        end
        CMP: begin
          gnt        <= '0;
          resp_valid <= 1'b1;
          resp_id    <= r_win_id;
          greater    <= (r_a >  r_b);
          equal      <= (r_a == r_b);
          smaller    <= (r_a <  r_b);
        end
        RESP: begin
          // The fairness pointer moves only when a result is actually consumed.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_last_id  <= resp_id;
          end
        end
        default: gnt <= '0;
      endcase
    end
  end

  // The operand registers need no reset. They are always written before the
  // comparator reads them.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any) begin
      r_a <= w_a;
      r_b <= w_b;
    end
  end

endmodule

// File: tb/tb_compare_arbiter.sv
module tb_compare_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        resp_ready = 1'b1;
  logic [3:0]  gnt;
  logic        busy, resp_valid, greater, equal, smaller;
  logic [1:0]  resp_id;

  compare_arbiter #(.CMP_WIDTH(4), .NUM_REQ(4), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .greater(greater), .equal(equal), .smaller(smaller)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic       g, e, s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    a_bus[i*4 +: 4] = a;
    b_bus[i*4 +: 4] = b;
  endtask

  // The expected result comes from the operands the bench itself drove.
  task push_exp(input int i);
    exp_t       e;
    logic [3:0] a, b;
    a    = a_bus[i*4 +: 4];
    b    = b_bus[i*4 +: 4];
    e.id = 2'(i);
    e.g  = (a > b);
    e.e  = (a == b);
    e.s  = (a < b);
    sb.push_back(e);
  endtask

  task chk_reset(input string tag);
    chk({tag, "_gnt"},   gnt,        0);
    chk({tag, "_busy"},  busy,       0);
    chk({tag, "_rv"},    resp_valid, 0);
    chk({tag, "_id"},    resp_id,    0);
    chk({tag, "_flags"}, {greater, equal, smaller}, 0);
  endtask

  // Wait at most maxw edges for a grant. Check it against the scoreboard head,
  // then check the result. The handshake is held off for 'hold' RESP cycles.
  task run_one(input int maxw, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (gnt == 4'b0 && n < maxw) begin
      tick;
      n++;
    end
    chk("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("gnt", gnt, 32'(1) << e.id);
      chk("busy_cmp", busy, 1);
      chk("rv_cmp", resp_valid, 0);
      req[e.id] = 1'b0;
      if (hold > 0) resp_ready = 1'b0;
      tick;
      chk("rv", resp_valid, 1);
      chk("id", resp_id, e.id);
      chk("flags", {greater, equal, smaller}, {e.g, e.e, e.s});
      chk("gnt_clr", gnt, 0);
      chk("busy_resp", busy, 1);
      for (int h = 0; h < hold; h++) begin
        tick;
        chk("bp_rv", resp_valid, 1);
        chk("bp_id", resp_id, e.id);
        chk("bp_flags", {greater, equal, smaller}, {e.g, e.e, e.s});
        chk("bp_busy", busy, 1);
        chk("bp_gnt", gnt, 0);
      end
      resp_ready = 1'b1;
      tick;
      chk("rv_done", resp_valid, 0);
    end
  endtask

  initial begin
    // Reset state.
    tick; tick;
    rst = 1'b0;
    chk_reset("rst");

    // A single request from requester 1: a=9, b=3.
    set_op(1, 4'd9, 4'd3);
    push_exp(1);
    req = 4'b0010;
    run_one(1, 0);

    // Round-robin order 0,1,2,3 from a fresh reset, then the subset 0,2.
    rst = 1'b1; tick; rst = 1'b0;
    set_op(0, 4'd1, 4'd2);
    set_op(1, 4'd7, 4'd7);
    set_op(2, 4'd12, 4'd5);
    set_op(3, 4'd3, 4'd8);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) push_exp(i);
    for (int i = 0; i < 4; i++) run_one(1, 0);
    req = 4'b0101;
    push_exp(0); push_exp(2);
    run_one(1, 0); run_one(1, 0);

    // Operand boundary values.
    set_op(0, 4'd0, 4'd15);  push_exp(0); req = 4'b0001; run_one(1, 0);
    set_op(3, 4'd15, 4'd15); push_exp(3); req = 4'b1000; run_one(1, 0);
    set_op(2, 4'd15, 4'd0);  push_exp(2); req = 4'b0100; run_one(1, 0);

    // Backpressure with all requesters active. last_id is now 2, so the order
    // is 3, then 0,1,2.
    set_op(0, 4'd5, 4'd4);
    set_op(1, 4'd2, 4'd9);
    set_op(3, 4'd10, 4'd10);
    req = 4'b1111;
    push_exp(3); push_exp(0); push_exp(1); push_exp(2);
    run_one(1, 5);
    run_one(1, 0); run_one(1, 0); run_one(1, 0);

    // Reset during CMP.
    req = 4'b0100;
    tick;
    chk("mid_gnt", gnt, 4'b0100);
    chk("mid_busy", busy, 1);
    rst = 1'b1; tick; rst = 1'b0;
    chk_reset("rst_cmp");
    // Reset during RESP.
    tick;
    chk("mid2_gnt", gnt, 4'b0100);
    tick;
    chk("mid2_rv", resp_valid, 1);
    rst = 1'b1; tick; rst = 1'b0;
    chk_reset("rst_resp");
    // The restored last_id makes requester 0 win first.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) push_exp(i);
    for (int i = 0; i < 4; i++) run_one(1, 0);

    // Idle stability.
    req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rv", resp_valid, 0);
    end
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
